// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_arb_pkg;

   localparam int DEV_W = 7;
   localparam int REG_W = 8;
   localparam int DAT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_NACK = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   // One register-level I2C command as latched from the winning requester.
   typedef struct packed {
      logic             rw;
      logic [DEV_W-1:0] dev;
      logic [REG_W-1:0] addr;
      logic [DAT_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
module i2c_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   logic [ID_W-1:0] pos;

   // Scan from the farthest offset down so the nearest requester at/after ptr wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = '0;
      gnt = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (req[pos]) begin
            any = 1'b1;
            idx = pos;
         end
      end
      if (any) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter + sequencer sharing one I2C master core between NUM_REQ requesters.
// Latency: >= 4 cycles per transaction (IDLE/ISSUE/WAIT/RESP) plus core time.
// Backpressure: holds cmd_valid until cmd_ready; other requests wait in IDLE for the next rotation.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a stalled core after TIMEOUT_CYCLES clocks.
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                     S00_AXI_aclk,
   input  logic                     S00_AXI_aresetn,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_rw,
   input  logic [NUM_REQ*DEV_W-1:0] req_dev,
   input  logic [NUM_REQ*REG_W-1:0] req_reg,
   input  logic [NUM_REQ*DAT_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [DAT_W-1:0]         rsp_rdata,
   output logic [1:0]               rsp_err,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic                     cmd_rw,
   output logic [DEV_W-1:0]         cmd_dev,
   output logic [REG_W-1:0]         cmd_reg,
   output logic [DAT_W-1:0]         cmd_wdata,
   input  logic                     core_done,
   input  logic                     core_nack,
   input  logic [DAT_W-1:0]         core_rdata,
   output logic                     core_abort,
   output logic                     busy
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("i2c_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   arb_state_t         state_q;
   arb_state_t         state_nxt;
   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    gnt_idx_q;
   logic [NUM_REQ-1:0] req_ready_q;
   cmd_t               cmd_q;
   cmd_t               pick_cmd;
   logic [DAT_W-1:0]   rdata_q;
   logic [1:0]         err_q;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               tmo_hit;

   i2c_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Mux the candidate requester's fields so they can be latched on the grant edge.
   always_comb begin
      pick_cmd       = '0;
      pick_cmd.rw    = req_rw[pick_idx];
      pick_cmd.dev   = req_dev[pick_idx*DEV_W +: DEV_W];
      pick_cmd.addr  = req_reg[pick_idx*REG_W +: REG_W];
      pick_cmd.wdata = req_wdata[pick_idx*DAT_W +: DAT_W];
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Watchdog counts cycles spent in ISSUE/WAIT and restarts on every state change.
   always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
      if (!S00_AXI_aresetn) begin
         cnt_q <= '0;
      end else if (state_nxt != state_q) begin
         cnt_q <= '0;
      end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A genuine completion on the last allowed cycle beats the timeout.
   assign tmo_hit = ((state_q == ST_ISSUE) || (state_q == ST_WAIT && !core_done)) &&
                    (cnt_q == CNT_MAX);
`else
   assign tmo_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
      if (!S00_AXI_aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic: one transaction in flight, IDLE always visited between grants.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (pick_any)                state_nxt = ST_ISSUE;
         ST_ISSUE: if (tmo_hit)                 state_nxt = ST_RESP;
                   else if (cmd_ready)          state_nxt = ST_WAIT;
         ST_WAIT:  if (core_done || tmo_hit)    state_nxt = ST_RESP;
         ST_RESP:                               state_nxt = ST_IDLE;
         default:                               state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch command on grant, capture result on completion, rotate pointer after response.
   always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
      if (!S00_AXI_aresetn) begin
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         req_ready_q <= '0;
         cmd_q       <= '0;
         rdata_q     <= '0;
         err_q       <= ERR_OK;
      end else begin
         req_ready_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  cmd_q       <= pick_cmd;
                  gnt_idx_q   <= pick_idx;
                  req_ready_q <= pick_gnt;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (tmo_hit) begin
                  rdata_q <= '0;
                  err_q   <= ERR_TMO;
               end else if (state_q == ST_WAIT && core_done) begin
                  rdata_q <= cmd_q.rw ? core_rdata : '0;
                  err_q   <= core_nack ? ERR_NACK : ERR_OK;
               end
            end
            ST_RESP: begin
               ptr_q <= (gnt_idx_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; response fields are zero outside the RESP pulse.
   always_comb begin
      rsp_valid  = '0;
      rsp_rdata  = '0;
      rsp_err    = ERR_OK;
      if (state_q == ST_RESP) begin
         rsp_valid[gnt_idx_q] = 1'b1;
         rsp_rdata            = rdata_q;
         rsp_err              = err_q;
      end
      req_ready  = req_ready_q;
      cmd_valid  = (state_q == ST_ISSUE);
      cmd_rw     = cmd_q.rw;
      cmd_dev    = cmd_q.dev;
      cmd_reg    = cmd_q.addr;
      cmd_wdata  = cmd_q.wdata;
      core_abort = tmo_hit;
      busy       = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: write, read, rotation, NACK, stall/timeout, mid-flight reset.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Each comparison is an immediate assertion feeding the summary counts.
module tb_i2c_req_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready, req_rw, rsp_valid;
   logic [27:0] req_dev;
   logic [31:0] req_reg, req_wdata;
   logic [7:0]  rsp_rdata, cmd_reg, cmd_wdata, core_rdata;
   logic [1:0]  rsp_err;
   logic        cmd_valid, cmd_ready, cmd_rw, core_done, core_nack, core_abort, busy;
   logic [6:0]  cmd_dev;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2c_req_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .S00_AXI_aclk    (clk),
      .S00_AXI_aresetn (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rw          (req_rw),
      .req_dev         (req_dev),
      .req_reg         (req_reg),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_rw          (cmd_rw),
      .cmd_dev         (cmd_dev),
      .cmd_reg         (cmd_reg),
      .cmd_wdata       (cmd_wdata),
      .core_done       (core_done),
      .core_nack       (core_nack),
      .core_rdata      (core_rdata),
      .core_abort      (core_abort),
      .busy            (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd);
      req_rw[i]           = rw;
      req_dev[i*7 +: 7]   = dev;
      req_reg[i*8 +: 8]   = rg;
      req_wdata[i*8 +: 8] = wd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
      chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'h0);
      chk({tag, "_cmd_fields"}, {15'h0, cmd_rw, cmd_dev, cmd_reg, cmd_wdata}, 32'h0);
      chk({tag, "_core_abort"}, 32'(core_abort), 32'h0);
      chk({tag, "_busy"},      32'(busy),      32'h0);
   endtask

   // Full transaction starting in IDLE with the request already presented.
   task automatic serve(input int exp, input logic [6:0] exp_dev, input logic nack);
      tick();
      chk("srv_ready", 32'(req_ready), 32'(1 << exp));
      chk("srv_dev",   32'(cmd_dev),   32'(exp_dev));
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("srv_wait_cmd_valid", 32'(cmd_valid), 32'h0);
      chk("srv_wait_ready",     32'(req_ready), 32'h0);
      core_done = 1'b1;
      core_nack = nack;
      tick();
      core_done = 1'b0;
      core_nack = 1'b0;
      chk("srv_rsp_valid", 32'(rsp_valid), 32'(1 << exp));
      chk("srv_rsp_err",   32'(rsp_err),   nack ? 32'h1 : 32'h0);
      tick();
      chk("srv_idle_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_abort;
      logic seen_rsp;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_rw     = '0;
      req_dev    = '0;
      req_reg    = '0;
      req_wdata  = '0;
      cmd_ready  = 1'b0;
      core_done  = 1'b0;
      core_nack  = 1'b0;
      core_rdata = '0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // 1: single write from requester 0
      set_req(0, 1'b0, 7'h1A, 8'h05, 8'h3C);
      req_valid = 4'b0001;
      tick();
      chk("t1_ready",     32'(req_ready), 32'h1);
      chk("t1_cmd_valid", 32'(cmd_valid), 32'h1);
      chk("t1_fields",    {15'h0, cmd_rw, cmd_dev, cmd_reg, cmd_wdata}, {15'h0, 1'b0, 7'h1A, 8'h05, 8'h3C});
      chk("t1_busy",      32'(busy), 32'h1);
      req_valid = 4'b0000;
      tick();
      chk("t1_hold_valid", 32'(cmd_valid), 32'h1);
      chk("t1_hold_ready", 32'(req_ready), 32'h0);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("t1_wait_cmd_valid", 32'(cmd_valid), 32'h0);
      core_done  = 1'b1;
      core_rdata = 8'hFF;
      tick();
      core_done = 1'b0;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_err",   32'(rsp_err),   32'h0);
      chk("t1_rsp_rdata", 32'(rsp_rdata), 32'h0);
      tick();
      chk("t1_idle_rsp", 32'(rsp_valid), 32'h0);
      chk("t1_idle_busy", 32'(busy), 32'h0);

      // 2: read from requester 2; core_done during ISSUE must be ignored
      set_req(2, 1'b1, 7'h50, 8'h10, 8'h00);
      req_valid = 4'b0100;
      tick();
      chk("t2_ready", 32'(req_ready), 32'h4);
      chk("t2_rw",    32'(cmd_rw),    32'h1);
      chk("t2_dev",   32'(cmd_dev),   32'h50);
      req_valid  = 4'b0000;
      core_done  = 1'b1;
      core_rdata = 8'h11;
      tick();
      core_done = 1'b0;
      chk("t2_issue_ignores_done", 32'(cmd_valid), 32'h1);
      chk("t2_no_early_rsp",       32'(rsp_valid), 32'h0);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("t2_wait_cmd_valid", 32'(cmd_valid), 32'h0);
      tick();
      chk("t2_wait_busy", 32'(busy), 32'h1);
      chk("t2_wait_rsp",  32'(rsp_valid), 32'h0);
      core_done  = 1'b1;
      core_rdata = 8'hA5;
      tick();
      core_done = 1'b0;
      chk("t2_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("t2_rsp_rdata", 32'(rsp_rdata), 32'hA5);
      chk("t2_rsp_err",   32'(rsp_err),   32'h0);
      tick();

      // 3: all four requesting continuously from reset -> 0,1,2,3,0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 7'(7'h20 + i), 8'(i), 8'(8'h80 + i));
      req_valid = 4'b1111;
      serve(0, 7'h20, 1'b0);
      serve(1, 7'h21, 1'b0);
      serve(2, 7'h22, 1'b0);
      serve(3, 7'h23, 1'b0);
      serve(0, 7'h20, 1'b0);

      // 4: NACK on requester 1, then pointer must sit at 2 (1 and 2 both requesting -> 2)
      req_valid = 4'b0010;
      serve(1, 7'h21, 1'b1);
      req_valid = 4'b0110;
      serve(2, 7'h22, 1'b0);
      req_valid = 4'b0000;

      // 5: stalled core (pointer at 3, only requester 0 asks)
      req_valid = 4'b0001;
      tick();
      chk("t5_ready", 32'(req_ready), 32'h1);
      req_valid = 4'b0000;
`ifdef I2C_ARB_TIMEOUT_EN
      repeat (14) tick();
      chk("t5_abort_early", 32'(core_abort), 32'h0);
      tick();
      chk("t5_abort_pulse", 32'(core_abort), 32'h1);
      tick();
      chk("t5_abort_done",  32'(core_abort), 32'h0);
      chk("t5_rsp_valid",   32'(rsp_valid),  32'h1);
      chk("t5_rsp_err",     32'(rsp_err),    32'h2);
      chk("t5_rsp_rdata",   32'(rsp_rdata),  32'h0);
      tick();
`else
      cmd_ready = 1'b1;
      tick();
      cmd_ready  = 1'b0;
      seen_abort = 1'b0;
      seen_rsp   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen_abort = seen_abort | core_abort;
         seen_rsp   = seen_rsp | (|rsp_valid);
      end
      chk("t5_no_abort", 32'(seen_abort), 32'h0);
      chk("t5_no_rsp",   32'(seen_rsp),   32'h0);
      chk("t5_busy",     32'(busy),       32'h1);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t5_rsp_err",   32'(rsp_err),   32'h0);
      tick();
`endif

      // 6: reset during WAIT discards the transaction
      req_valid = 4'b0001;
      tick();
      chk("t6_ready", 32'(req_ready), 32'h1);
      req_valid = 4'b0000;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("t6_in_wait", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("t6_reset");
      tick();
      tick();
      rst_n    = 1'b1;
      seen_rsp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen_rsp = seen_rsp | (|rsp_valid);
      end
      chk("t6_no_rsp", 32'(seen_rsp), 32'h0);
      set_req(3, 1'b1, 7'h3B, 8'h44, 8'h00);
      req_valid = 4'b1000;
      tick();
      chk("t6_ready3", 32'(req_ready), 32'h8);
      chk("t6_dev3",   32'(cmd_dev),   32'h3B);
      req_valid = 4'b0000;
      cmd_ready = 1'b1;
      tick();
      cmd_ready  = 1'b0;
      core_done  = 1'b1;
      core_rdata = 8'h5E;
      tick();
      core_done = 1'b0;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'h8);
      chk("t6_rsp_rdata", 32'(rsp_rdata), 32'h5E);
      tick();
      chk("t6_idle", 32'(busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
